// File: rtl/mem_pkg.sv
// mem_pkg: shared types and helpers for the load/store sequencer.
//   size_t     - access size, same encoding as the extender SELECT input
//   state_t    - sequencer states
//   size_bytes - number of bytes moved by an access of a given size
//   misaligned - natural-alignment check on the low address bits
package mem_pkg;

    typedef enum logic [1:0] {
        SZ_D = 2'b00,
        SZ_W = 2'b01,
        SZ_H = 2'b10,
        SZ_B = 2'b11
    } size_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RD   = 2'b01,
        WR   = 2'b10,
        DONE = 2'b11
    } state_t;

    function automatic logic [3:0] size_bytes(input size_t sz);
        case (sz)
            SZ_D:    return 4'd8;
            SZ_W:    return 4'd4;
            SZ_H:    return 4'd2;
            default: return 4'd1;
        endcase
    endfunction

    // An access is aligned when the offset is a multiple of its size.
    function automatic logic misaligned(input size_t sz, input logic [2:0] off);
        case (sz)
            SZ_D:    return off != 3'b000;
            SZ_W:    return off[1:0] != 2'b00;
            SZ_H:    return off[0];
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/store_merge.sv
// store_merge: combinational byte-lane merge for sub-doubleword stores.
//   old_data - doubleword read back from memory
//   new_data - store data, valid bytes right-aligned in the LSBs
//   offset   - byte offset of the access inside the doubleword
//   size     - access size (size_t)
//   merged   - old_data with lanes offset..offset+n-1 replaced by new_data
// Callers only present naturally aligned accesses, so the lane window never
// runs past lane 7.
module store_merge
    import mem_pkg::*;
(
    input  logic [63:0] old_data,
    input  logic [63:0] new_data,
    input  logic [2:0]  offset,
    input  size_t       size,
    output logic [63:0] merged
);

    logic [63:0] base_mask;
    logic [63:0] lane_mask;
    logic [63:0] shifted;

    always_comb begin
        case (size)
            SZ_D:    base_mask = 64'hFFFF_FFFF_FFFF_FFFF;
            SZ_W:    base_mask = 64'h0000_0000_FFFF_FFFF;
            SZ_H:    base_mask = 64'h0000_0000_0000_FFFF;
            default: base_mask = 64'h0000_0000_0000_00FF;
        endcase
    end

    // Move both the data and its lane mask up to the addressed byte.
    assign shifted   = new_data  << {offset, 3'b000};
    assign lane_mask = base_mask << {offset, 3'b000};
    assign merged    = (old_data & ~lane_mask) | (shifted & lane_mask);

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store sequencer between the datapath and a 64-bit
// data memory with variable latency.
//   clk, reset            - rising-edge clock, async active-high reset
//   start/is_store/size/addr/wdata - access request, captured when IDLE
//   mem_req/mem_we/mem_addr/mem_wdata - memory request, held until accepted
//   mem_ready/mem_rdata   - memory completion and read data
//   busy/done/err         - status; done is a one-cycle pulse, err valid with it
//   load_data/load_size   - right-aligned, zero-filled load result and its size
//   dbg_state             - current sequencer state
//
// Memory handshake: a request is presented while mem_req=1 and completes in
// the cycle where mem_req && mem_ready; mem_addr/mem_we/mem_wdata are held
// stable until then, and mem_ready is ignored while mem_req=0. All memory
// outputs are registers or state decodes, so none depends on an input.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              is_store,
    input  logic [1:0]        size,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] load_data,
    output logic [1:0]        load_size,
    output state_t            dbg_state
);

    state_t            state;
    state_t            next_state;
    logic              accept;
    logic              store_q;
    size_t             size_q;
    logic [2:0]        off_q;
    logic [DATA_W-1:0] wdata_q;
    logic              err_q;
    logic [DATA_W-1:0] merge_out;
    logic [DATA_W-1:0] rd_shift;
    logic [DATA_W-1:0] rd_aligned;

    assign accept = (state == IDLE) && start;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (start) begin
                    if (misaligned(size_t'(size), addr[2:0])) begin
                        next_state = DONE;
                    end else if (is_store && (size_t'(size) == SZ_D)) begin
                        next_state = WR;
                    end else begin
                        next_state = RD;
                    end
                end
            end
            RD: begin
                if (mem_ready) begin
                    next_state = store_q ? WR : DONE;
                end
            end
            WR: begin
                if (mem_ready) begin
                    next_state = DONE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Outputs decoded straight from state; reset clears them without a clock.
    assign mem_req   = (state == RD) || (state == WR);
    assign mem_we    = (state == WR);
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign err       = (state == DONE) && err_q;
    assign dbg_state = state;

    store_merge u_store_merge (
        .old_data (mem_rdata),
        .new_data (wdata_q),
        .offset   (off_q),
        .size     (size_q),
        .merged   (merge_out)
    );

    // Right-align the addressed bytes and clear everything above the size.
    always_comb begin
        rd_shift = mem_rdata >> {off_q, 3'b000};
        case (size_q)
            SZ_D:    rd_aligned = rd_shift;
            SZ_W:    rd_aligned = {32'h0, rd_shift[31:0]};
            SZ_H:    rd_aligned = {48'h0, rd_shift[15:0]};
            default: rd_aligned = {56'h0, rd_shift[7:0]};
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            store_q   <= 1'b0;
            size_q    <= SZ_D;
            off_q     <= 3'b000;
            wdata_q   <= '0;
            err_q     <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            load_data <= '0;
            load_size <= 2'b00;
        end else begin
            if (accept) begin
                store_q   <= is_store;
                size_q    <= size_t'(size);
                off_q     <= addr[2:0];
                wdata_q   <= wdata;
                err_q     <= misaligned(size_t'(size), addr[2:0]);
                mem_addr  <= {addr[ADDR_W-1:3], 3'b000};
                // A doubleword store writes wdata as-is; a sub-doubleword
                // store overwrites this with the merge after the read.
                mem_wdata <= wdata;
            end
            if ((state == RD) && mem_ready) begin
                if (store_q) begin
                    mem_wdata <= merge_out;
                end else begin
                    load_data <= rd_aligned;
                    load_size <= size_q;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: randomized bench for mem_access_unit against a
// byte-addressed reference memory.
module tb_mem_access_unit;
    import mem_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        is_store;
    logic [1:0]  size;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic        mem_req;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic        mem_ready;
    logic [63:0] mem_rdata;
    logic        busy;
    logic        done;
    logic        err;
    logic [63:0] load_data;
    logic [1:0]  load_size;
    state_t      dbg_state;

    int tests_run    = 0;
    int tests_failed = 0;

    // Memory contents keyed by doubleword-aligned address.
    logic [63:0] mem [logic [63:0]];
    // Scoreboard: expected load_data at each completion.
    logic [63:0] exp_q[$];
    logic [63:0] exp_load_data = 64'h0;

    mem_access_unit #(.ADDR_W(64), .DATA_W(64)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .is_store  (is_store),
        .size      (size),
        .addr      (addr),
        .wdata     (wdata),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .load_data (load_data),
        .load_size (load_size),
        .dbg_state (dbg_state)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] rd_word(input logic [63:0] a);
        logic [63:0] k;
        k = a & ~64'h7;
        if (!mem.exists(k)) mem[k] = {$urandom, $urandom};
        return mem[k];
    endfunction

    function automatic logic [7:0] rd_byte(input logic [63:0] a);
        logic [63:0] w;
        w = rd_word(a);
        return w[8*int'(a[2:0]) +: 8];
    endfunction

    function automatic int nbytes(input logic [1:0] sz);
        case (sz)
            2'b00:   return 8;
            2'b01:   return 4;
            2'b10:   return 2;
            default: return 1;
        endcase
    endfunction

    // Drive one access and act as the memory. Each request waits a random
    // number of cycles in [wmin,wmax]; noisy pulses start while busy.
    task automatic do_access(input logic st, input logic [1:0] sz, input logic [63:0] a,
                             input logic [63:0] wd, input int wmin, input int wmax,
                             input bit noisy);
        int          n, base, cycles, waits, ntx, exp_tx, w, wcnt;
        bit          mis;
        logic [63:0] dw, exp_ld, exp_wr;

        n      = nbytes(sz);
        mis    = (a % 64'(n)) != 0;
        dw     = a & ~64'h7;
        exp_ld = 64'h0;
        exp_wr = rd_word(a);
        for (int k = 0; k < n; k++) begin
            exp_ld = exp_ld | (64'(rd_byte(a + 64'(k))) << (8 * k));
            exp_wr[8*int'(((a + 64'(k)) % 8)) +: 8] = wd[8*k +: 8];
        end
        base   = mis ? 1 : ((!st || sz == 2'b00) ? 2 : 3);
        exp_tx = mis ? 0 : ((st && sz != 2'b00) ? 2 : 1);
        if (!mis && !st) exp_load_data = exp_ld;
        exp_q.push_back(exp_load_data);

        @(negedge clk);
        start = 1'b1; is_store = st; size = sz; addr = a; wdata = wd;
        @(negedge clk);
        start = 1'b0; is_store = 1'($urandom); size = 2'($urandom);
        addr = {$urandom, $urandom}; wdata = {$urandom, $urandom};
        if (mis) check("mis_no_req", mem_req, 0);
        cycles = 1; waits = 0; ntx = 0; wcnt = 0;
        w = $urandom_range(wmin, wmax);
        while (!done && cycles < 60) begin
            if (mem_req) begin
                check("mem_addr", mem_addr, dw);
                if (mem_we) check("mem_wdata", mem_wdata, exp_wr);
                mem_rdata = rd_word(mem_addr);
                if (wcnt < w) begin
                    mem_ready = 1'b0;
                    wcnt++;
                    waits++;
                end else begin
                    mem_ready = 1'b1;
                    check("mem_we", mem_we, 64'(st && (sz == 2'b00 || ntx == 1)));
                    if (mem_we) mem[dw] = mem_wdata;
                    ntx++;
                    wcnt = 0;
                    w = $urandom_range(wmin, wmax);
                end
            end else begin
                mem_ready = 1'($urandom);
                mem_rdata = {$urandom, $urandom};
            end
            if (noisy) start = 1'($urandom);
            @(negedge clk);
            cycles++;
        end
        check("done_seen", done, 1);
        check("latency", cycles, base + waits);
        check("n_tx", ntx, exp_tx);
        check("err", err, 64'(mis));
        check("load_data", load_data, exp_q.pop_front());
        if (!mis && !st) check("load_size", load_size, sz);
        if (!mis && st) check("mem_content", mem[dw], exp_wr);
        // start during the DONE cycle must be ignored
        start = 1'($urandom);
        mem_ready = 1'($urandom);
        @(negedge clk);
        start = 1'b0;
        mem_ready = 1'b0;
        check("done_pulse", done, 0);
        check("idle_after", busy, 0);
    endtask

    initial begin
        logic [1:0]  r_sz;
        logic [63:0] r_a;
        int          r_n;

        reset = 1'b1; start = 1'b0; is_store = 1'b0; size = 2'b00;
        addr = 64'h0; wdata = 64'h0; mem_ready = 1'b0; mem_rdata = 64'h0;
        repeat (3) @(negedge clk);
        check("rst_req", mem_req, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_load_data", load_data, 0);
        reset = 1'b0;

        // Byte load, immediate ready
        mem[64'h1000] = 64'h8877_6655_4433_2211;
        do_access(1'b0, 2'b11, 64'h1005, 64'h0, 0, 0, 1'b0);
        check("byte_load_val", load_data, 64'h66);

        // Word store via read-modify-write
        mem[64'h2000] = 64'hFFFF_FFFF_FFFF_FFFF;
        do_access(1'b1, 2'b01, 64'h2004, 64'hDEAD_BEEF, 0, 0, 1'b0);
        check("word_store_mem", mem[64'h2000], 64'hDEAD_BEEF_FFFF_FFFF);

        // Doubleword load with three wait states
        mem[64'h1008] = 64'h0123_4567_89AB_CDEF;
        do_access(1'b0, 2'b00, 64'h1008, 64'h0, 3, 3, 1'b0);
        check("dword_load_val", load_data, 64'h0123_4567_89AB_CDEF);

        // Misaligned half load
        do_access(1'b0, 2'b10, 64'h3003, 64'h0, 0, 0, 1'b0);

        // start pulses while a load is outstanding
        do_access(1'b0, 2'b01, 64'h1010, 64'h0, 2, 4, 1'b1);

        // Reset while a read is waiting
        @(negedge clk);
        start = 1'b1; is_store = 1'b0; size = 2'b00; addr = 64'h1018;
        @(negedge clk);
        start = 1'b0; mem_ready = 1'b0;
        check("pre_rst_req", mem_req, 1);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_req", mem_req, 0);
        check("mid_rst_we", mem_we, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_err", err, 0);
        check("mid_rst_addr", mem_addr, 0);
        check("mid_rst_wdata", mem_wdata, 0);
        check("mid_rst_load_data", load_data, 0);
        check("mid_rst_load_size", load_size, 0);
        @(negedge clk);
        check("rst_no_done", done, 0);
        reset = 1'b0;
        exp_load_data = 64'h0;
        do_access(1'b0, 2'b10, 64'h1016, 64'h0, 0, 1, 1'b0);

        // Random accesses in a small region so stores feed later loads
        for (int i = 0; i < 150; i++) begin
            r_sz = 2'($urandom);
            r_n  = nbytes(r_sz);
            r_a  = 64'h1000 + 64'($urandom_range(0, 63));
            if ($urandom_range(0, 2) != 0) r_a = r_a & ~64'(r_n - 1);
            do_access(1'($urandom), r_sz, r_a, {$urandom, $urandom},
                      0, $urandom_range(0, 3), 1'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
